apb_timer: RTL

APB slave timer on one of the bridge's PSEL lines: a 32-bit down-counter with an 8-bit prescaler, periodic or one-shot mode, and a level interrupt. Software programs it through four word registers. It runs on the system clock and answers with zero wait states, so bridge transfers complete in the minimum APB cycle count.

---
 rtl/apb_timer_pkg.sv | 33 +++
 rtl/apb_timer_prescaler.sv | 39 +++
 rtl/apb_timer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/apb_timer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_timer_pkg : register map, CTRL bit positions and byte-lane merge helper
// Rev 1.0
// ----------------------------------------------------------------------------
package apb_timer_pkg;

  localparam logic [11:0] TIMER_CTRL_OFS    = 12'h000;
  localparam logic [11:0] TIMER_LOAD_OFS    = 12'h004;
  localparam logic [11:0] TIMER_VALUE_OFS   = 12'h008;
  localparam logic [11:0] TIMER_INTSTAT_OFS = 12'h00C;

  localparam int EN           = 0;
  localparam int IE           = 1;
  localparam int ONESHOT      = 2;
  localparam int PRESCALE_LSB = 8;
  localparam int PRESCALE_MSB = 15;

  // Implemented CTRL bits; everything else reads back as zero.
  localparam logic [31:0] C_CTRL_MASK = 32'h0000_FF07;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_timer_prescaler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_timer_prescaler : 8-bit prescale counter emitting one tick per period
// Rev 1.0
// ----------------------------------------------------------------------------
module apb_timer_prescaler
  import apb_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] prescale,
  input  logic       clr,
  output logic       tick
);

  logic [7:0] ps_q;
  logic [7:0] ps_d;

  assign tick = en & (ps_q == prescale);

  // A clear coinciding with a tick still lets that tick through.
  always_comb begin
    ps_d = ps_q + 8'd1;
    if (!en || clr || tick) begin
      ps_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_timer : APB slave 32-bit down-counter timer with prescaler and level IRQ
// Rev 1.0
// ----------------------------------------------------------------------------
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        PSEL,
  input  logic [11:0] PADDR,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  input  logic [2:0]  PPROT,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        timer_irq
);

  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] value_q, value_d;
  logic        intstat_q, intstat_d;

  logic [11:0] w_ofs;
  logic        w_access;
  logic        w_mapped;
  logic        w_err;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_load;
  logic        w_wr_int;
  logic        w_tick;
  logic        w_ps_clr;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^{PPROT, PADDR[1:0]};

  assign w_ofs    = {PADDR[11:2], 2'b00};
  assign w_access = PSEL & PENABLE;
  assign w_mapped = (w_ofs == TIMER_CTRL_OFS)  | (w_ofs == TIMER_LOAD_OFS) |
                    (w_ofs == TIMER_VALUE_OFS) | (w_ofs == TIMER_INTSTAT_OFS);
  assign w_err    = w_access & (~w_mapped | (PWRITE & (w_ofs == TIMER_VALUE_OFS)));
  assign w_wr     = w_access & PWRITE & ~w_err;

  assign w_wr_ctrl = w_wr & (w_ofs == TIMER_CTRL_OFS);
  assign w_wr_load = w_wr & (w_ofs == TIMER_LOAD_OFS);
  assign w_wr_int  = w_wr & (w_ofs == TIMER_INTSTAT_OFS);

  assign PREADY    = 1'b1;
  assign PSLVERR   = w_err;
  assign timer_irq = intstat_q & ctrl_q[IE];

  always_comb begin
    w_rdata = '0;
    if (PSEL && !w_err) begin
      case (w_ofs)
        TIMER_CTRL_OFS:    w_rdata = ctrl_q;
        TIMER_LOAD_OFS:    w_rdata = load_q;
        TIMER_VALUE_OFS:   w_rdata = value_q;
        TIMER_INTSTAT_OFS: w_rdata = {31'b0, intstat_q};
        default:           w_rdata = '0;
      endcase
    end
  end

  assign PRDATA = w_rdata;

  // Ordering encodes the collision rules: the tick's set beats a W1C clear,
  // while software CTRL/LOAD writes override what the tick did.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    value_d   = value_q;
    intstat_d = intstat_q;

    if (w_wr_int && PSTRB[0] && PWDATA[0]) begin
      intstat_d = 1'b0;
    end

    if (w_tick) begin
      if (value_q != '0) begin
        value_d = value_q - 32'd1;
      end else begin
        intstat_d = 1'b1;
        if (ctrl_q[ONESHOT]) begin
          ctrl_d[EN] = 1'b0;
        end else begin
          value_d = load_q;
        end
      end
    end

    if (w_wr_ctrl) begin
      ctrl_d = strb_merge(ctrl_d, PWDATA, PSTRB) & C_CTRL_MASK;
    end

    if (w_wr_load) begin
      load_d  = strb_merge(load_q, PWDATA, PSTRB);
      value_d = load_d;
    end
  end

  assign w_ps_clr = w_wr_load | (w_wr_ctrl & ~ctrl_q[EN] & ctrl_d[EN]);

  apb_timer_prescaler u_prescaler (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .en       (ctrl_q[EN]),
    .prescale (ctrl_q[PRESCALE_MSB:PRESCALE_LSB]),
    .clr      (w_ps_clr),
    .tick     (w_tick)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ctrl_q    <= '0;
      load_q    <= RESET_LOAD;
      value_q   <= RESET_LOAD;
      intstat_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      value_q   <= value_d;
      intstat_q <= intstat_d;
    end
  end

endmodule
`default_nettype wire
